// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   localparam int XLEN_DEF = 64;
   localparam int ILEN_DEF = 32;
   localparam logic [XLEN_DEF-1:0] PC_INC = 64'd4;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [ILEN_DEF-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } ifu_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries with flush; head is read
// combinationally so an entry is visible the cycle after it is pushed.
module fetch_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == {CW{1'b0}});
   assign count_o   = count_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;

   // Pointer and occupancy next-state; flush empties the buffer outright.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer/occupancy state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (push_ok_s && !flush_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, BOOT/RUN(/HALT) FSM, imem handshake and fetch buffer.
// Optional misaligned-redirect trap enabled by IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter int              XLEN       = XLEN_DEF,
   parameter int              ILEN       = ILEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_addr,
   output logic            imem_req,
   input  logic            imem_ready,
   input  logic [ILEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [ILEN-1:0] if_instr,
`ifdef IFU_MISALIGN_TRAP_EN
   output logic            fetch_misaligned,
`endif
   output logic [XLEN-1:0] if_pc
);

   localparam int EW = $bits(fetch_entry_t);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] redir_pc_s;
   logic            redir_misal_s;
   logic            accept_s, pop_s;
   logic            fifo_full_s, fifo_empty_s;
   logic [CW-1:0]   fifo_count_s;
   fetch_entry_t    push_entry_s, head_entry_s;

`ifdef IFU_MISALIGN_TRAP_EN
   logic misal_q, misal_d;
   assign redir_pc_s       = redirect_pc;
   assign redir_misal_s    = (redirect_pc[1:0] != 2'b00);
   assign fetch_misaligned = misal_q;
`else
   assign redir_pc_s    = {redirect_pc[XLEN-1:2], 2'b00};
   assign redir_misal_s = 1'b0;
`endif

   assign imem_addr = pc_q;
   assign imem_req  = (state_q == ST_RUN) && !fifo_full_s && !redirect_valid;
   assign accept_s  = imem_req && imem_ready;
   assign if_valid  = !fifo_empty_s;
   assign pop_s     = if_valid && if_ready;

   assign push_entry_s.pc    = XLEN_DEF'(pc_q);
   assign push_entry_s.instr = ILEN_DEF'(imem_rdata);
   assign if_pc              = XLEN'(head_entry_s.pc);
   assign if_instr           = ILEN'(head_entry_s.instr);

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fetch_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (accept_s),
      .push_data_i (push_entry_s),
      .pop_i       (pop_s),
      .flush_i     (redirect_valid),
      .head_o      (head_entry_s),
      .count_o     (fifo_count_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s)
   );

   // FSM and PC next-state; a redirect overrides both.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef IFU_MISALIGN_TRAP_EN
      misal_d = misal_q;
`endif
      if (redirect_valid) begin
         pc_d    = redir_pc_s;
         state_d = redir_misal_s ? ST_HALT : ST_RUN;
`ifdef IFU_MISALIGN_TRAP_EN
         misal_d = redir_misal_s;
`endif
      end else begin
         case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
               if (accept_s) begin
                  pc_d = pc_q + XLEN'(PC_INC);
               end else begin
                  pc_d = pc_q;
               end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
         endcase
      end
   end

   // State and PC registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
`ifdef IFU_MISALIGN_TRAP_EN
         misal_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
`ifdef IFU_MISALIGN_TRAP_EN
         misal_q <= misal_d;
`endif
      end
   end

   logic unused_s;
   assign unused_s = ^fifo_count_s;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + randomized bench for instruction_fetch_unit against a queue-based model.
module tb_instruction_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] imem_addr;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
`ifdef IFU_MISALIGN_TRAP_EN
   logic        fetch_misaligned;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: PC, queue of {pc, instr}, boot/halt flags.
   logic [63:0] m_pc;
   logic [95:0] m_q[$];
   bit          m_boot;
   bit          m_halt;
   bit          m_mis;

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .XLEN       (64),
      .ILEN       (32),
      .RESET_PC   (64'h0),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_req       (imem_req),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
`ifdef IFU_MISALIGN_TRAP_EN
      .fetch_misaligned (fetch_misaligned),
`endif
      .if_pc          (if_pc)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic rdy);
      reset          = 1'b1;
      imem_ready     = rdy;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      imem_rdata     = $urandom;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      m_pc   = 64'h0;
      m_q.delete();
      m_boot = 1'b1;
      m_halt = 1'b0;
      m_mis  = 1'b0;
   endtask

   // One cycle: drive, check outputs on the falling edge, advance model at the rising edge.
   task automatic step(input logic rdy, input logic ifr, input logic rv, input logic [63:0] rpc);
      logic exp_req;
      logic acc;
      logic pop;
      imem_ready     = rdy;
      if_ready       = ifr;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_rdata     = $urandom;
      @(negedge clk);
      exp_req = !m_boot && !m_halt && (m_q.size() < DEPTH) && !rv;
      chk("imem_addr", imem_addr, m_pc);
      chk("imem_req", {63'h0, imem_req}, {63'h0, exp_req});
      chk("if_valid", {63'h0, if_valid}, {63'h0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
         chk("if_pc", if_pc, m_q[0][95:32]);
         chk("if_instr", {32'h0, if_instr}, {32'h0, m_q[0][31:0]});
      end
`ifdef IFU_MISALIGN_TRAP_EN
      chk("fetch_misaligned", {63'h0, fetch_misaligned}, {63'h0, m_mis});
`endif
      acc = exp_req && rdy;
      pop = (m_q.size() != 0) && ifr;
      if (rv) begin
`ifdef IFU_MISALIGN_TRAP_EN
         m_pc   = rpc;
         m_halt = (rpc % 4 != 0);
         m_mis  = m_halt;
`else
         m_pc = rpc - (rpc % 4);
`endif
         m_q.delete();
      end else begin
         if (pop) void'(m_q.pop_front());
         if (acc) begin
            m_q.push_back({m_pc, imem_rdata});
            m_pc = m_pc + 64'd4;
         end
      end
      m_boot = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic r_rdy, r_ifr, r_rv;
      logic [63:0] r_pc;

      do_reset(1'b0);
      chk("reset_if_valid", {63'h0, if_valid}, 64'h0);
      chk("reset_imem_req", {63'h0, imem_req}, 64'h0);
      chk("reset_imem_addr", imem_addr, 64'h0);
      chk("reset_if_instr", {32'h0, if_instr}, 64'h0);
      chk("reset_if_pc", if_pc, 64'h0);

      // Streaming at full throughput.
      repeat (8) step(1'b1, 1'b1, 1'b0, 64'h0);

      // Decode stalled: buffer fills with PCs 0 and 4, then drains in order.
      do_reset(1'b0);
      repeat (6) step(1'b1, 1'b0, 1'b0, 64'h0);
      chk("stall_addr_held", imem_addr, 64'h8);
      repeat (3) step(1'b0, 1'b1, 1'b0, 64'h0);

      // Redirect with a full buffer flushes it.
      do_reset(1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 64'h0);
      step(1'b1, 1'b1, 1'b1, 64'h100);
      chk("redirect_addr", imem_addr, 64'h100);
      repeat (4) step(1'b1, 1'b1, 1'b0, 64'h0);

      // PC wraps modulo 2^64.
      step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      repeat (3) step(1'b1, 1'b1, 1'b0, 64'h0);

      // Misaligned redirect, then recovery.
      step(1'b1, 1'b1, 1'b1, 64'h102);
      repeat (3) step(1'b1, 1'b1, 1'b0, 64'h0);
      step(1'b1, 1'b1, 1'b1, 64'h200);
      repeat (3) step(1'b1, 1'b1, 1'b0, 64'h0);

      // Reset while an accept is in flight.
      do_reset(1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 64'h0);
      do_reset(1'b1);
      chk("rst_mid_if_valid", {63'h0, if_valid}, 64'h0);
      chk("rst_mid_imem_addr", imem_addr, 64'h0);
      repeat (4) step(1'b1, 1'b1, 1'b0, 64'h0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         r_rdy = 1'($urandom_range(0, 1));
         r_ifr = 1'($urandom_range(0, 1));
         r_rv  = ($urandom_range(0, 9) == 0);
         r_pc  = {$urandom, $urandom};
         if (i % 150 == 149) begin
            do_reset(r_rdy);
         end else begin
            step(r_rdy, r_ifr, r_rv, r_pc);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
